// File: rtl/cursor_ctrl_if.sv
// cursor_ctrl_if: key input, cursor/blink outputs, board-memory and generation-engine handshake
interface cursor_ctrl_if #(
   parameter int XW = 5,
   parameter int YW = 5
);
   logic [2:0]       keys;
   logic [XW-1:0]    cur_x;
   logic [YW-1:0]    cur_y;
   logic             cursor_on;
   logic [XW+YW-1:0] mem_addr;
   logic             mem_rd;
   logic             mem_rdata;
   logic             mem_wr;
   logic             mem_wdata;
   logic             gen_start;
   logic             gen_busy;
   logic             busy;
   modport master (
      input  keys, mem_rdata, gen_busy,
      output cur_x, cur_y, cursor_on, mem_addr, mem_rd, mem_wr, mem_wdata, gen_start, busy
   );
   modport slave (
      output keys, mem_rdata, gen_busy,
      input  cur_x, cur_y, cursor_on, mem_addr, mem_rd, mem_wr, mem_wdata, gen_start, busy
   );
endinterface

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: turns touch key events into cursor moves, cell flips and generation requests
module cursor_ctrl #(
   parameter int COLS      = 32,
   parameter int ROWS      = 32,
   parameter int XW        = 5,
   parameter int YW        = 5,
   parameter int BLINK_DIV = 8
) (
   input logic          clk,
   input logic          reset,
   cursor_ctrl_if.master bus
);
   localparam logic [2:0] KEY_IDLE  = 3'd0;
   localparam logic [2:0] KEY_UP    = 3'd1;
   localparam logic [2:0] KEY_DOWN  = 3'd2;
   localparam logic [2:0] KEY_LEFT  = 3'd3;
   localparam logic [2:0] KEY_RIGHT = 3'd4;
   localparam logic [2:0] KEY_FLIP  = 3'd5;
   localparam logic [2:0] KEY_NXT   = 3'd6;
   localparam int CW = $clog2(BLINK_DIV);

   typedef enum logic [2:0] {IDLE, FLIP_RD, FLIP_WR, GEN_REQ, GEN_HOLD, GEN_WAIT} state_t;

   state_t        state;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;
   logic          pend_v;
   logic [2:0]    pend_k;
   logic [CW-1:0] blink_cnt;
   logic          cursor_on, mem_rd, mem_wr, gen_start;
   logic          in_ok, key_ok, is_move;
   logic [2:0]    key;

   // key selection: a buffered key takes priority over the live input in IDLE
   always_comb begin
      in_ok   = bus.keys != KEY_IDLE && bus.keys <= KEY_NXT;
      key     = pend_v ? pend_k : bus.keys;
      key_ok  = state == IDLE && (pend_v || in_ok);
      is_move = key_ok && key >= KEY_UP && key <= KEY_RIGHT;
   end

   // control FSM, cursor position and one-entry pending key buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur_x     <= '0;
         cur_y     <= '0;
         pend_v    <= 1'b0;
         pend_k    <= KEY_IDLE;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         gen_start <= 1'b0;
      end else begin
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         gen_start <= 1'b0;
         if (state == IDLE ? pend_v : in_ok) begin
            pend_v <= in_ok;
            pend_k <= bus.keys;
         end
         case (state)
            IDLE: if (key_ok) begin
               case (key)
                  KEY_UP:    cur_y <= (cur_y == '0) ? YW'(ROWS - 1) : cur_y - YW'(1);
                  KEY_DOWN:  cur_y <= (cur_y == YW'(ROWS - 1)) ? '0 : cur_y + YW'(1);
                  KEY_LEFT:  cur_x <= (cur_x == '0) ? XW'(COLS - 1) : cur_x - XW'(1);
                  KEY_RIGHT: cur_x <= (cur_x == XW'(COLS - 1)) ? '0 : cur_x + XW'(1);
                  KEY_FLIP:  begin state <= FLIP_RD; mem_rd <= 1'b1; end
                  KEY_NXT:   begin state <= GEN_REQ; gen_start <= 1'b1; end
                  default:   ;
               endcase
            end
            FLIP_RD:  begin state <= FLIP_WR; mem_wr <= 1'b1; end
            FLIP_WR:  state <= IDLE;
            GEN_REQ:  state <= GEN_HOLD;
            GEN_HOLD: state <= GEN_WAIT;
            GEN_WAIT: if (!bus.gen_busy) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   // cursor blink divider, restarted visible by every executed move
   always_ff @(posedge clk) begin
      if (reset || is_move) begin
         cursor_on <= 1'b1;
         blink_cnt <= '0;
      end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
         cursor_on <= ~cursor_on;
         blink_cnt <= '0;
      end else begin
         blink_cnt <= blink_cnt + CW'(1);
      end
   end

   assign bus.cur_x     = cur_x;
   assign bus.cur_y     = cur_y;
   assign bus.cursor_on = cursor_on;
   assign bus.mem_addr  = {cur_y, cur_x};
   assign bus.mem_rd    = mem_rd;
   assign bus.mem_wr    = mem_wr;
   assign bus.mem_wdata = state == FLIP_WR && !bus.mem_rdata;
   assign bus.gen_start = gen_start;
   assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: vector table plus write/generation scoreboard for cursor_ctrl
module tb_cursor_ctrl;
   localparam logic [2:0] KI = 3'd0, KU = 3'd1, KD = 3'd2, KL = 3'd3, KR = 3'd4, KF = 3'd5, KN = 3'd6, KX = 3'd7;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   wr_count = 0;
   int   gen_cnt = 0;
   logic mem [1024];

   typedef struct {logic is_gen; int addr; logic data;} exp_t;
   typedef struct {logic sel; logic [2:0] k; int x; int y; logic on;} vec_t;
   exp_t sb[$];
   vec_t vt [18];

   always #5 clk = ~clk;

   cursor_ctrl_if #(.XW(5), .YW(5)) b0 ();
   cursor_ctrl_if #(.XW(3), .YW(2)) b1 ();

   cursor_ctrl #(.COLS(32), .ROWS(32), .XW(5), .YW(5), .BLINK_DIV(8)) u0 (.clk(clk), .reset(reset), .bus(b0.master));
   cursor_ctrl #(.COLS(5),  .ROWS(3),  .XW(3), .YW(2), .BLINK_DIV(8)) u1 (.clk(clk), .reset(reset), .bus(b1.master));

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] k);
      b0.keys = k;
      tick();
      b0.keys = KI;
   endtask

   // board memory, generation engine and scoreboard monitor for the 32x32 instance
   initial begin
      b0.mem_rdata = 1'b0;
      b0.gen_busy  = 1'b0;
      b1.mem_rdata = 1'b0;
      b1.gen_busy  = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
      forever begin
         exp_t e;
         tick();
         if (b0.mem_wr) begin
            wr_count++;
            chk("sb_has_wr", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("sb_kind_wr", 0, e.is_gen);
               chk("sb_wr_addr", b0.mem_addr, e.addr);
               chk("sb_wr_data", b0.mem_wdata, e.data);
            end
            mem[b0.mem_addr] = b0.mem_wdata;
         end
         if (b0.gen_start) begin
            chk("sb_has_gen", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("sb_kind_gen", 1, e.is_gen);
            end
            gen_cnt = 20;
         end else if (gen_cnt > 0) begin
            gen_cnt--;
         end
         b0.gen_busy = gen_cnt > 0;
         if (b0.mem_rd) b0.mem_rdata = mem[b0.mem_addr];
      end
   end

   initial begin
      int n;
      int wrs;
      logic exp_on;
      b0.keys = KI;
      b1.keys = KI;
      vt = '{
         '{1'b0, KL, 31, 0, 1'b1}, '{1'b0, KU, 31, 31, 1'b1}, '{1'b0, KR, 0, 31, 1'b1},
         '{1'b0, KD, 0, 0, 1'b1},  '{1'b0, KD, 0, 1, 1'b1},   '{1'b0, KR, 1, 1, 1'b1},
         '{1'b0, KX, 1, 1, 1'b1},  '{1'b0, KI, 1, 1, 1'b1},
         '{1'b1, KR, 1, 0, 1'b1},  '{1'b1, KR, 2, 0, 1'b1},   '{1'b1, KR, 3, 0, 1'b1},
         '{1'b1, KR, 4, 0, 1'b1},  '{1'b1, KR, 0, 0, 1'b1},   '{1'b1, KD, 0, 1, 1'b1},
         '{1'b1, KD, 0, 2, 1'b1},  '{1'b1, KD, 0, 0, 1'b1},   '{1'b1, KL, 4, 0, 1'b1},
         '{1'b1, KU, 4, 2, 1'b1}
      };
      tick();
      tick();
      reset = 1'b0;
      chk("rst_x", b0.cur_x, 0);
      chk("rst_y", b0.cur_y, 0);
      chk("rst_on", b0.cursor_on, 1);
      chk("rst_rd", b0.mem_rd, 0);
      chk("rst_wr", b0.mem_wr, 0);
      chk("rst_wdata", b0.mem_wdata, 0);
      chk("rst_gen", b0.gen_start, 0);
      chk("rst_busy", b0.busy, 0);

      for (int i = 0; i < 18; i++) begin
         if (vt[i].sel) b1.keys = vt[i].k;
         else b0.keys = vt[i].k;
         tick();
         b0.keys = KI;
         b1.keys = KI;
         chk($sformatf("vec%0d_x", i), vt[i].sel ? 32'(b1.cur_x) : 32'(b0.cur_x), vt[i].x);
         chk($sformatf("vec%0d_y", i), vt[i].sel ? 32'(b1.cur_y) : 32'(b0.cur_y), vt[i].y);
         chk($sformatf("vec%0d_on", i), vt[i].sel ? b1.cursor_on : b0.cursor_on, vt[i].on);
         if (!vt[i].sel) chk($sformatf("vec%0d_addr", i), b0.mem_addr, vt[i].y * 32 + vt[i].x);
      end

      send(KR); send(KR); send(KD); send(KD); send(KD);
      chk("flip_addr", b0.mem_addr, 32'h83);
      for (int r = 0; r < 2; r++) begin
         sb.push_back('{1'b0, 32'h83, r == 0});
         send(KF);
         chk("flip_t1_rd", b0.mem_rd, 1);
         chk("flip_t1_wr", b0.mem_wr, 0);
         chk("flip_t1_busy", b0.busy, 1);
         tick();
         chk("flip_t2_wr", b0.mem_wr, 1);
         chk("flip_t2_wdata", b0.mem_wdata, r == 0);
         chk("flip_t2_addr", b0.mem_addr, 32'h83);
         tick();
         chk("flip_t3_busy", b0.busy, 0);
         chk("flip_t3_wr", b0.mem_wr, 0);
      end

      sb.push_back('{1'b1, 0, 1'b0});
      send(KN);
      chk("gen_start", b0.gen_start, 1);
      chk("gen_busy_out", b0.busy, 1);
      n = 0;
      while (b0.busy && n < 100) begin
         b0.keys = (n == 5) ? KR : (n == 8) ? KD : KI;
         tick();
         n++;
         if (n == 1) chk("gen_start_pulse", b0.gen_start, 0);
      end
      b0.keys = KI;
      chk("gen_wait_cycles", n, 21);
      chk("gen_frozen_x", b0.cur_x, 3);
      chk("gen_frozen_y", b0.cur_y, 4);
      tick();
      chk("pend_x", b0.cur_x, 3);
      chk("pend_y", b0.cur_y, 5);
      tick();
      chk("pend_once_y", b0.cur_y, 5);

      send(KF);
      chk("rst_flip_rd", b0.mem_rd, 1);
      b0.keys = KU;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      b0.keys = KI;
      wrs = wr_count;
      chk("abort_busy", b0.busy, 0);
      chk("abort_wr", b0.mem_wr, 0);
      chk("abort_x", b0.cur_x, 0);
      chk("abort_y", b0.cur_y, 0);
      chk("abort_on", b0.cursor_on, 1);
      repeat (3) tick();
      chk("abort_no_wr", wr_count, wrs);
      chk("abort_pend_y", b0.cur_y, 0);

      for (int m = 0; m < 2; m++) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         for (int k = 1; k <= 24; k++) begin
            b0.keys = (m == 1 && k == 13) ? KR : KI;
            tick();
            b0.keys = KI;
            exp_on = (m == 0) ? ((k / 8) % 2 == 0) : (k < 8 || (k >= 13 && k < 21));
            chk($sformatf("blink%0d_c%0d", m, k), b0.cursor_on, exp_on);
         end
      end
      chk("blink_move_x", b0.cur_x, 1);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
